// File: rtl/act_seq.sv
// FP16 activation sequencer: credit-issued buffer reads, 3-deep result FIFO.
// Optional negative-input statistics with ACT_SEQ_STATS_EN.
module act_seq #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              relu_mode,
  output logic              busy,
  output logic              done,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  input  logic [15:0]       buf_rd_data,
  output logic              act_en,
  output logic [15:0]       act_i,
  input  logic [15:0]       act_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic              out_last
`ifdef ACT_SEQ_STATS_EN
  ,
  output logic [LEN_W-1:0]  neg_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic              relu_q;
  logic [LEN_W-1:0]  issued_q;
  logic [LEN_W-1:0]  acc_q;
  logic              infl_q;
  logic [15:0]       mem_q [0:2];
  logic [1:0]        wr_q;
  logic [1:0]        rd_q;
  logic [1:0]        cnt_q, cnt_d;

  logic              start_acc;
  logic [2:0]        occ;
  logic              rd_go;
  logic              push;
  logic              pop;
  logic [LEN_W-1:0]  len_m1;
  logic              last_hs;

  assign start_acc = (state_q == S_IDLE) && start;
  assign occ       = {1'b0, cnt_q} + {2'b00, infl_q};
  // credits count words already in flight, so the FIFO cannot overflow
  assign rd_go     = (state_q == S_RUN) && (issued_q < len_q)
                     && (occ < 3'd3);
  assign push      = infl_q;
  assign pop       = out_valid && out_ready;
  assign len_m1    = len_q - LEN_W'(1);
  assign last_hs   = pop && (acc_q == len_m1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = (len == '0) ? S_DONE : S_RUN;
      S_RUN:  if (last_hs) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    buf_rd_en   = rd_go;
    buf_rd_addr = rd_go ? base_q + ADDR_W'(issued_q) : '0;
    act_en      = relu_q;
    act_i       = buf_rd_data;
    out_valid   = (cnt_q != 2'd0);
    out_data    = out_valid ? mem_q[rd_q] : 16'h0000;
    out_last    = out_valid && (acc_q == len_m1);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (!push && pop) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      len_q    <= '0;
      relu_q   <= 1'b0;
      issued_q <= '0;
      acc_q    <= '0;
      infl_q   <= 1'b0;
      wr_q     <= 2'd0;
      rd_q     <= 2'd0;
      cnt_q    <= 2'd0;
    end else begin
      if (start_acc) begin
        base_q   <= base_addr;
        len_q    <= len;
        relu_q   <= relu_mode;
        issued_q <= '0;
        acc_q    <= '0;
      end
      infl_q <= rd_go;
      if (rd_go) issued_q <= issued_q + LEN_W'(1);
      if (push)  wr_q <= (wr_q == 2'd2) ? 2'd0 : wr_q + 2'd1;
      if (pop) begin
        rd_q  <= (rd_q == 2'd2) ? 2'd0 : rd_q + 2'd1;
        acc_q <= acc_q + LEN_W'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= act_z;
  end

`ifdef ACT_SEQ_STATS_EN
  logic [LEN_W-1:0] neg_q;

  always_ff @(posedge clk) begin
    if (rst)                          neg_q <= '0;
    else if (start_acc)               neg_q <= '0;
    else if (push && buf_rd_data[15]) neg_q <= neg_q + LEN_W'(1);
  end

  assign neg_count = neg_q;
`endif

endmodule
